alu_issue: RTL

Operand-fetch and write-back stage placed directly upstream of the 8-bit registered ALU. It holds a small register file and accepts one instruction at a time through a valid/ready handshake. For each instruction it drives registered operands and the 4-bit opcode onto the ALU inputs, waits out the ALU's two-edge latency, then writes the ALU result back to the destination register.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_issue_if.sv | 26 ++
 rtl/alu_regfile.sv | 44 ++++
 rtl/alu_issue.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, data width and issue FSM states
package alu_pkg;
    localparam int DW = 8;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_SHL = 4'b1101;
    localparam logic [3:0] OP_ROR = 4'b1110;
    localparam logic [3:0] OP_ROL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_e;
endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction handshake and write-back report channel
interface alu_issue_if #(parameter int AW = 2);
    import alu_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          in_li;
    logic [DW-1:0] in_imm;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_li, in_imm,
        input  in_ready, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_li, in_imm,
        output in_ready, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x DW register file, two operand reads, host read, host/WB writes
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rs2_data,
    output logic [DW-1:0] rd_data,
    input  logic          hw_en,
    input  logic [AW-1:0] hw_addr,
    input  logic [DW-1:0] hw_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    // Write-back is applied last so it overrides a colliding host write.
    always_comb begin
        regs_d = regs_q;
        if (hw_en) regs_d[hw_addr] = hw_data;
        if (wb_en) regs_d[wb_addr] = wb_data;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rs1_data = regs_q[rs1_addr];
    assign rs2_data = regs_q[rs2_addr];
    assign rd_data  = regs_q[rd_addr];
endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - operand fetch / write-back stage for the 2-edge registered ALU
// Define ALU_LI_EN to enable the load-immediate path (IDLE -> WB).
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          ck,
    input  logic          rst,
    alu_issue_if.slave    ib,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_ctr,
    input  logic [DW-1:0] alu_o,
    input  logic          hw_en,
    input  logic [AW-1:0] hw_addr,
    input  logic [DW-1:0] hw_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    state_e        state_q, state_d;
    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]    alu_ctr_q, alu_ctr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] rs1_data, rs2_data, wb_src;
    logic          wb_en;

`ifdef ALU_LI_EN
    logic          li_q, li_d;
    logic [DW-1:0] imm_q, imm_d;
    assign wb_src = li_q ? imm_q : alu_o;
`else
    logic unused_li;
    assign unused_li = ^{ib.in_li, ib.in_imm};
    assign wb_src    = alu_o;
`endif

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_ctr_d = alu_ctr_q;
        rd_d      = rd_q;
`ifdef ALU_LI_EN
        li_d      = li_q;
        imm_d     = imm_q;
`endif
        case (state_q)
            IDLE: begin
                if (ib.in_valid) begin
                    rd_d    = ib.in_rd;
                    state_d = ISSUE;
`ifdef ALU_LI_EN
                    li_d  = ib.in_li;
                    imm_d = ib.in_imm;
                    if (ib.in_li) state_d = WB;
`endif
                    // Operand registers only move on an ALU-path accept.
                    if (state_d == ISSUE) begin
                        alu_a_d   = rs1_data;
                        alu_b_d   = rs2_data;
                        alu_ctr_d = ib.in_op;
                    end
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_ctr_q <= '0;
            rd_q      <= '0;
`ifdef ALU_LI_EN
            li_q      <= 1'b0;
            imm_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_ctr_q <= alu_ctr_d;
            rd_q      <= rd_d;
`ifdef ALU_LI_EN
            li_q      <= li_d;
            imm_q     <= imm_d;
`endif
        end
    end

    assign wb_en       = (state_q == WB);
    assign ib.in_ready = (state_q == IDLE);
    assign ib.wb_valid = wb_en;
    assign ib.wb_addr  = rd_q;
    assign ib.wb_data  = wb_en ? wb_src : '0;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctr     = alu_ctr_q;

    alu_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
        .ck       (ck),
        .rst      (rst),
        .rs1_addr (ib.in_rs1),
        .rs2_addr (ib.in_rs2),
        .rd_addr  (rd_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_data  (rd_data),
        .hw_en    (hw_en),
        .hw_addr  (hw_addr),
        .hw_data  (hw_data),
        .wb_en    (wb_en),
        .wb_addr  (rd_q),
        .wb_data  (wb_src)
    );
endmodule
